// File: rtl/f2sdram_pkg.sv
// Shared definitions for the f2sdram burst writer slice.
//   wr_state_t        : burst writer FSM states
//   BYTEENABLE_WIDTH  : byteenable width of the default 64-bit f2sdram port
//   ADDRESS_WIDTH     : word address width of the default 64-bit f2sdram port
//   addr_width()      : word address width for an arbitrary data width
package f2sdram_pkg;

   localparam int unsigned DEF_DATA_WIDTH       = 64;
   localparam int unsigned DEF_BURSTCOUNT_WIDTH = 8;
   localparam int unsigned BYTEENABLE_WIDTH     = DEF_DATA_WIDTH / 8;
   localparam int unsigned ADDRESS_WIDTH        = 32 - $clog2(BYTEENABLE_WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_BURST,
      ST_DONE
   } wr_state_t;

   // Avalon word address width: 32-bit byte address minus byte-lane bits.
   function automatic int unsigned addr_width(input int unsigned dw);
      return 32 - $clog2(dw / 8);
   endfunction

endpackage

// File: rtl/f2sdram_burst_writer_if.sv
// Avalon-MM burst write bus between the burst writer and the f2sdram port
// (or the safe terminator in front of it).
//   master : burst writer side (drives burstcount/address/writedata/
//            byteenable/write, receives waitrequest)
//   slave  : memory side
interface f2sdram_burst_writer_if
   import f2sdram_pkg::*;
#(
   parameter int unsigned DATA_WIDTH       = DEF_DATA_WIDTH,
   parameter int unsigned BURSTCOUNT_WIDTH = DEF_BURSTCOUNT_WIDTH
);

   localparam int unsigned AW = addr_width(DATA_WIDTH);

   logic                        waitrequest;
   logic [BURSTCOUNT_WIDTH-1:0] burstcount;
   logic [AW-1:0]               address;
   logic [DATA_WIDTH-1:0]       writedata;
   logic [DATA_WIDTH/8-1:0]     byteenable;
   logic                        write;

   modport master (
      input  waitrequest,
      output burstcount, address, writedata, byteenable, write
   );

   modport slave (
      output waitrequest,
      input  burstcount, address, writedata, byteenable, write
   );

endinterface

// File: rtl/f2sdram_wr_fifo.sv
// Show-ahead staging FIFO for the burst writer.
//   clk, rst_n : clock, asynchronous active-low reset (clears pointers/count)
//   push/wr_data : write side; ignored when full
//   pop/rd_data  : read side; rd_data is the current head (zero pop latency)
//   count/full/empty : occupancy status
module f2sdram_wr_fifo
   import f2sdram_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned DEPTH = 256
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/f2sdram_burst_writer.sv
// Streams a job of `length` words from a valid/ready source into SDRAM
// through an Avalon-MM burst write master (f2sdram port). Words are staged
// in a show-ahead FIFO; a burst is only issued once all of its words are
// present, so a granted beat never waits on the source.
//   clk, reset_n        : clock, asynchronous active-low reset
//   start/base_addr/length : one-cycle job request (word address, word count)
//   busy, done          : job active; one-cycle completion pulse
//   in_data/in_valid/in_ready : source stream
//   av                  : Avalon burst write master
module f2sdram_burst_writer
   import f2sdram_pkg::*;
#(
   parameter int unsigned DATA_WIDTH       = 64,
   parameter int unsigned BURSTCOUNT_WIDTH = 8,
   parameter int unsigned MAX_BURST        = 128,
   parameter int unsigned FIFO_DEPTH       = 256,
   parameter int unsigned LEN_WIDTH        = 24
)(
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic                                 start,
   input  logic [31-$clog2(DATA_WIDTH/8):0]     base_addr,
   input  logic [LEN_WIDTH-1:0]                 length,
   output logic                                 busy,
   output logic                                 done,
   input  logic [DATA_WIDTH-1:0]                in_data,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   f2sdram_burst_writer_if.master               av
);

   localparam int unsigned AW  = addr_width(DATA_WIDTH);
   localparam int unsigned BEW = DATA_WIDTH / 8;
   localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;

   // Reset asserts asynchronously, releases two clocks after reset_n rises.
   logic [1:0] rst_sync;
   logic       rst_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rst_sync <= '0;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign rst_n = rst_sync[1];

   wr_state_t                   state;
   logic [AW-1:0]               addr;
   logic [LEN_WIDTH-1:0]        remaining;
   logic [LEN_WIDTH-1:0]        len_q;
   logic [LEN_WIDTH-1:0]        accepted;
   logic [BURSTCOUNT_WIDTH-1:0] beat_cnt;
   logic [BURSTCOUNT_WIDTH-1:0] blen;

   logic                        write_q;
   logic [BURSTCOUNT_WIDTH-1:0] burstcount_q;
   logic [AW-1:0]               address_q;
   logic [BEW-1:0]              byteenable_q;

   logic [DATA_WIDTH-1:0]       fifo_rd_data;
   logic [CW-1:0]               fifo_count;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic                        push;
   logic                        pop;

   assign blen = (remaining > LEN_WIDTH'(MAX_BURST)) ? BURSTCOUNT_WIDTH'(MAX_BURST)
                                                     : BURSTCOUNT_WIDTH'(remaining);

   assign in_ready = busy && !fifo_full && (accepted < len_q);
   assign push     = in_valid && in_ready;
   assign pop      = write_q && !av.waitrequest && !fifo_empty;

   assign av.write      = write_q;
   assign av.burstcount = burstcount_q;
   assign av.address    = address_q;
   assign av.byteenable = byteenable_q;
   assign av.writedata  = fifo_rd_data;

   f2sdram_wr_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .wr_data (in_data),
      .pop     (pop),
      .rd_data (fifo_rd_data),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         addr         <= '0;
         remaining    <= '0;
         len_q        <= '0;
         accepted     <= '0;
         beat_cnt     <= '0;
         write_q      <= 1'b0;
         burstcount_q <= '0;
         address_q    <= '0;
         byteenable_q <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         if (push) begin
            accepted <= accepted + LEN_WIDTH'(1);
         end

         case (state)
            ST_IDLE: begin
               if (start) begin
                  // Length is latched even when zero so in_ready stays low.
                  len_q     <= length;
                  remaining <= length;
                  accepted  <= '0;
                  addr      <= base_addr;
                  busy      <= 1'b1;
                  if (length == '0) begin
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end else begin
                     state <= ST_FILL;
                  end
               end
            end

            ST_FILL: begin
               if (32'(fifo_count) >= 32'(blen)) begin
                  write_q      <= 1'b1;
                  burstcount_q <= blen;
                  address_q    <= addr;
                  byteenable_q <= '1;
                  beat_cnt     <= blen;
                  state        <= ST_BURST;
               end
            end

            ST_BURST: begin
               if (pop) begin
                  remaining <= remaining - LEN_WIDTH'(1);
                  beat_cnt  <= beat_cnt - BURSTCOUNT_WIDTH'(1);
                  if (beat_cnt == BURSTCOUNT_WIDTH'(1)) begin
                     write_q      <= 1'b0;
                     burstcount_q <= '0;
                     byteenable_q <= '0;
                     // Wraps modulo 2^AW by construction.
                     addr         <= addr + AW'(burstcount_q);
                     if (remaining != LEN_WIDTH'(1)) begin
                        state <= ST_FILL;
                     end else begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                     end
                  end
               end
            end

            ST_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_f2sdram_burst_writer.sv
module tb_f2sdram_burst_writer;
   import f2sdram_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        start = 1'b0;
   logic [28:0] base_addr = '0;
   logic [23:0] length = '0;
   logic        busy;
   logic        done;
   logic [63:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;

   f2sdram_burst_writer_if #(.DATA_WIDTH(64), .BURSTCOUNT_WIDTH(8)) av ();

   f2sdram_burst_writer #(
      .DATA_WIDTH       (64),
      .BURSTCOUNT_WIDTH (8),
      .MAX_BURST        (128),
      .FIFO_DEPTH       (256),
      .LEN_WIDTH        (24)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .busy      (busy),
      .done      (done),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .av        (av)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] pat(input int j, input int i);
      return {16'(j), 16'hA5A5, 32'(i)};
   endfunction

   typedef struct {
      logic [28:0] a;
      logic [7:0]  c;
   } burst_t;

   burst_t      exp_b[$];
   logic [63:0] exp_d[$];

   // ---------------- source stream / waitrequest driver ----------------
   int src_idx = 0;
   int src_acc = 0;
   int src_job = 0;
   bit src_en  = 1'b0;
   bit gappy   = 1'b0;
   bit wrand   = 1'b0;

   initial begin
      bit hs;
      av.waitrequest = 1'b0;
      forever begin
         @(negedge clk);
         hs = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (hs) begin
            src_idx++;
            src_acc++;
         end
         in_data        = pat(src_job, src_idx);
         in_valid       = src_en && (!gappy || ($urandom_range(0, 3) != 0));
         av.waitrequest = wrand && ($urandom_range(0, 2) == 0);
      end
   end

   // ---------------- monitor ----------------
   bit          mon_active = 1'b0;
   int          mon_beat = 0;
   logic [28:0] mon_addr;
   logic [7:0]  mon_bc;
   int unsigned last_beat_cyc = 0;

   always @(negedge clk) begin
      if (reset_n) begin
         if (av.write && !mon_active) begin
            mon_active = 1'b1;
            mon_beat   = 0;
            mon_addr   = av.address;
            mon_bc     = av.burstcount;
            if (exp_b.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_burst actual addr=%0h count=%0d required no burst",
                        av.address, av.burstcount);
            end else begin
               burst_t b;
               b = exp_b.pop_front();
               chk("burst_address", 64'(av.address), 64'(b.a));
               chk("burst_count", 64'(av.burstcount), 64'(b.c));
            end
         end else if (mon_active) begin
            chk("write_held", 64'(av.write), 64'(1));
            chk("address_stable", 64'(av.address), 64'(mon_addr));
            chk("burstcount_stable", 64'(av.burstcount), 64'(mon_bc));
         end
         if (mon_active && av.write && !av.waitrequest) begin
            chk("byteenable", 64'(av.byteenable), 64'hFF);
            if (exp_d.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_beat actual data=%0h required no beat", av.writedata);
            end else begin
               chk("beat_data", av.writedata, exp_d.pop_front());
            end
            last_beat_cyc = cyc;
            mon_beat++;
            if (mon_beat == int'(mon_bc)) begin
               mon_active = 1'b0;
               mon_beat   = 0;
            end
         end
      end
   end

   // ---------------- job helpers ----------------
   int unsigned issue_cyc;
   int unsigned done_cyc;

   task automatic exp_burst(input logic [28:0] a, input logic [7:0] c);
      burst_t b;
      b.a = a;
      b.c = c;
      exp_b.push_back(b);
   endtask

   task automatic issue_job(input int job, input logic [28:0] b, input int len,
                            input bit g, input bit w);
      for (int i = 0; i < len; i++) exp_d.push_back(pat(job, i));
      @(posedge clk);
      #2;
      src_idx   = 0;
      src_acc   = 0;
      src_job   = job;
      src_en    = 1'b1;
      gappy     = g;
      wrand     = w;
      start     = 1'b1;
      base_addr = b;
      length    = 24'(len);
      issue_cyc = cyc;
      @(posedge clk);
      #2;
      start     = 1'b0;
      base_addr = '0;
      length    = '0;
   endtask

   task automatic wait_job(input int len);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 20000; n++) begin
         @(negedge clk);
         if (done) begin
            seen     = 1'b1;
            done_cyc = cyc;
            break;
         end
      end
      chk("done_seen", 64'(seen), 64'(1));
      if (seen) begin
         @(negedge clk);
         #1;
         chk("done_one_cycle", 64'(done), 64'(0));
         chk("busy_after", 64'(busy), 64'(0));
         chk("in_ready_after", 64'(in_ready), 64'(0));
         chk("words_accepted", 64'(src_acc), 64'(len));
         chk("bursts_left", 64'(exp_b.size()), 64'(0));
         chk("beats_left", 64'(exp_d.size()), 64'(0));
         repeat (3) @(negedge clk);
         chk("no_extra_accept", 64'(src_acc), 64'(len));
      end
      src_en = 1'b0;
      gappy  = 1'b0;
      wrand  = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bit found;

      #1 reset_n = 1'b0;
      #2;
      chk("rst_write", 64'(av.write), 64'(0));
      chk("rst_burstcount", 64'(av.burstcount), 64'(0));
      chk("rst_address", 64'(av.address), 64'(0));
      chk("rst_byteenable", 64'(av.byteenable), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(0));
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      // Single short burst, done one cycle after the last beat.
      exp_burst(29'h100, 8'd4);
      issue_job(1, 29'h100, 4, 1'b0, 1'b0);
      wait_job(4);
      chk("done_latency", 64'(done_cyc), 64'(last_beat_cyc + 1));

      // Zero-length job: done quickly, no write.
      issue_job(2, 29'h555, 0, 1'b0, 1'b0);
      wait_job(0);
      chk("len0_latency_ok", 64'((done_cyc - issue_cyc) <= 2), 64'(1));

      // 300 words split 128/128/44; a second start mid-job is ignored.
      exp_burst(29'h2000, 8'd128);
      exp_burst(29'h2080, 8'd128);
      exp_burst(29'h2100, 8'd44);
      issue_job(3, 29'h2000, 300, 1'b0, 1'b0);
      repeat (30) @(posedge clk);
      #2;
      start     = 1'b1;
      base_addr = 29'h7777;
      length    = 24'd9;
      @(posedge clk);
      #2;
      start     = 1'b0;
      base_addr = '0;
      length    = '0;
      chk("busy_during_job", 64'(busy), 64'(1));
      wait_job(300);

      // Random waitrequest and source gaps.
      exp_burst(29'h1000, 8'd128);
      exp_burst(29'h1080, 8'd72);
      issue_job(4, 29'h1000, 200, 1'b1, 1'b1);
      wait_job(200);

      // Address at the top of the space and wrap between bursts.
      exp_burst(29'h1FFFFFFE, 8'd4);
      issue_job(5, 29'h1FFFFFFE, 4, 1'b0, 1'b0);
      wait_job(4);
      exp_burst(29'h1FFFFFC0, 8'd128);
      exp_burst(29'h00000040, 8'd2);
      issue_job(6, 29'h1FFFFFC0, 130, 1'b0, 1'b0);
      wait_job(130);

      // Reset during beat 3 of 8, then a fresh job.
      exp_burst(29'h200, 8'd8);
      issue_job(7, 29'h200, 8, 1'b0, 1'b0);
      found = 1'b0;
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         #1;
         if (mon_beat == 3) begin
            found = 1'b1;
            break;
         end
      end
      chk("beat3_reached", 64'(found), 64'(1));
      reset_n = 1'b0;
      #1;
      chk("midrst_write", 64'(av.write), 64'(0));
      chk("midrst_busy", 64'(busy), 64'(0));
      chk("midrst_in_ready", 64'(in_ready), 64'(0));
      chk("midrst_address", 64'(av.address), 64'(0));
      chk("midrst_burstcount", 64'(av.burstcount), 64'(0));
      chk("midrst_fifo_count", 64'(dut.u_fifo.count), 64'(0));
      exp_b.delete();
      exp_d.delete();
      mon_active = 1'b0;
      mon_beat   = 0;
      src_en     = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      exp_burst(29'h300, 8'd2);
      issue_job(8, 29'h300, 2, 1'b0, 1'b0);
      wait_job(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/f2sdram_burst_writer.md
F2SDRAM_BURST_WRITER -- requirements
Module: f2sdram_burst_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, Avalon data width in bits.
REQ-002 SHALL have parameter BURSTCOUNT_WIDTH, default 8, width of burstcount.
REQ-003 SHALL have parameter MAX_BURST, default 128, largest burst issued (1..2^(BURSTCOUNT_WIDTH-1)).
REQ-004 SHALL have parameter FIFO_DEPTH, default 256, staging FIFO words (power of 2, >= MAX_BURST).
REQ-005 SHALL have parameter LEN_WIDTH, default 24, width of the job length in words.
REQ-006 SHALL have port clk  input  1  single clock, same as the f2sdram port clock.
REQ-007 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port start  input  1  one-cycle job request.
REQ-009 SHALL have port base_addr  input  32-$clog2(DATA_WIDTH/8)  word address of the first beat.
REQ-010 SHALL have port length  input  LEN_WIDTH  job size in words.
REQ-011 SHALL have ports busy (1) and done (1), both outputs: job active; one-cycle completion pulse.
REQ-012 SHALL have ports in_data (DATA_WIDTH, input), in_valid (1, input) and in_ready (1, output): source stream.
REQ-013 SHALL have Avalon master ports waitrequest (input), burstcount, address, writedata, byteenable and write (outputs), widths matching the f2sdram slave port.

Function
REQ-014 SHALL run FSM states IDLE, FILL, BURST, DONE.
REQ-015 IDLE: on start with length>0, SHALL latch base_addr and length, set remaining=length and accepted=0, and go to FILL; with length==0, SHALL go to DONE; start SHALL be ignored outside IDLE.
REQ-016 SHALL compute blen = min(MAX_BURST, remaining).
REQ-017 FILL: when FIFO count >= blen, SHALL go to BURST with write=1, burstcount=blen, address=current address, and the first FIFO word on writedata.
REQ-018 BURST: address and burstcount SHALL be held constant for the whole burst; byteenable SHALL be all ones; write SHALL stay high until the last beat.
REQ-019 A beat is accepted when write && !waitrequest; on acceptance the FIFO SHALL pop, and the beat counter and remaining SHALL decrement.
REQ-020 After the last beat of a burst: if remaining>0, address SHALL advance by blen words and the FSM SHALL return to FILL (minimum 1 idle cycle between bursts); else the FSM SHALL go to DONE.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE; busy=1 in all states except IDLE.
REQ-022 in_ready SHALL equal busy && FIFO not full && accepted<length; a word is pushed when in_valid && in_ready; accepted SHALL never exceed length.
REQ-023 Address arithmetic SHALL wrap modulo 2^address width with no error flag.
REQ-024 A simultaneous push and pop SHALL leave the FIFO count unchanged; FIFO full and FIFO empty SHALL never stall a granted beat, because bursts start only with blen words present.
REQ-025 writedata SHALL come from the FIFO head with no added register stage; pop latency SHALL be zero (first-word fall-through).

Reset
REQ-026 Asserting reset_n low SHALL force IDLE and clear the FIFO, counters and latches; write=0, burstcount=0, address=0, byteenable=0, busy=0, done=0, in_ready=0.
REQ-027 Reset mid-burst SHALL drop write immediately; completing the in-flight burst is the job of the downstream safe terminator, which SHALL be placed between this block and f2sdram.
REQ-028 Reset deassertion SHALL be synchronized inside the block (2-flop) before it releases the FSM.

Structure
REQ-029 The FSM state enum and the Avalon width constants (BYTEENABLE_WIDTH, ADDRESS_WIDTH) SHALL live in the shared package f2sdram_pkg.
REQ-030 The staging FIFO SHALL be a sub-module f2sdram_wr_fifo (show-ahead, with count output).

Verification
REQ-031 length=4, base=0x100, stream always valid, waitrequest=0 -> one burst: burstcount=4, address=0x100, 4 consecutive beats, done 1 cycle after the last beat.
REQ-032 length=300, MAX_BURST=128 -> bursts of 128/128/44 at base, base+128, base+256; exactly 300 words accepted; in_ready=0 afterwards.
REQ-033 waitrequest asserted on random cycles -> address/burstcount stable during the burst; beat data in order; no beat lost or duplicated.
REQ-034 length=0 -> done pulses within 2 cycles, write never asserted; start while busy -> ignored, no change to the job.
REQ-035 reset_n pulsed low during beat 3 of 8 -> write=0 and FIFO empty the same cycle; after release, a new length=2 job completes normally.
REQ-036 base=2^29-2, length=4 (DATA_WIDTH=64) -> single burst at 0x1FFFFFFE; next job address wraps with no error.
